// File: rtl/proc_pkg.sv
// proc_pkg: shared widths, NOP opcode and instruction field positions for the processor pipeline
package proc_pkg;
  localparam int DATA_W  = 8;
  localparam int REG_CNT = 8;
  localparam int ADDR_W  = 3;
  localparam int OP_W    = 4;
  localparam int INSTR_W = 16;
  localparam logic [OP_W-1:0] OP_NOP = 4'h0;
  localparam int OP_LSB  = 12;
  localparam int RD_LSB  = 9;
  localparam int RS1_LSB = 6;
  localparam int RS2_LSB = 3;
endpackage

// File: rtl/opfetch_stage_if.sv
// opfetch_if: fetch->opfetch handshake, opfetch->execute handshake, writeback port and stall flag
//   slave modport  = operand-fetch stage side; master modport = surrounding pipeline/testbench side
interface opfetch_if;
  import proc_pkg::*;
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic               ex_valid;
  logic               ex_ready;
  logic [OP_W-1:0]    ex_op;
  logic [ADDR_W-1:0]  ex_rd;
  logic [DATA_W-1:0]  ex_a;
  logic [DATA_W-1:0]  ex_b;
  logic               wb_en;
  logic [ADDR_W-1:0]  wb_addr;
  logic [DATA_W-1:0]  wb_data;
  logic               stall;
  modport slave (
    input  in_valid, in_instr, ex_ready, wb_en, wb_addr, wb_data,
    output in_ready, ex_valid, ex_op, ex_rd, ex_a, ex_b, stall
  );
  modport master (
    output in_valid, in_instr, ex_ready, wb_en, wb_addr, wb_data,
    input  in_ready, ex_valid, ex_op, ex_rd, ex_a, ex_b, stall
  );
endinterface

// File: rtl/regfile_8x8.sv
// regfile_8x8: 8x8 register file, two combinational reads, one sync write, sync active-low reset
//   ports: clk, rst_n, ra1/ra2 -> rd1/rd2 read ports, we/wa/wd write port
//   OPFETCH_WB_BYPASS_EN: a read of the register being written returns wd in the same cycle
module regfile_8x8
  import proc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd
);
  logic [DATA_W-1:0] mem_q [REG_CNT];
  logic [DATA_W-1:0] mem_d [REG_CNT];
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[wa] = wd;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) mem_q <= '{default: '0};
    else        mem_q <= mem_d;
  end
`ifdef OPFETCH_WB_BYPASS_EN
  always_comb begin
    rd1 = (we && wa == ra1) ? wd : mem_q[ra1];
    rd2 = (we && wa == ra2) ? wd : mem_q[ra2];
  end
`else
  always_comb begin
    rd1 = mem_q[ra1];
    rd2 = mem_q[ra2];
  end
`endif
endmodule

// File: rtl/opfetch_stage.sv
// opfetch_stage: decode, register read, RAW scoreboard and execute-stage output register
//   ports: clk, rst_n (sync active-low), bus (opfetch_if.slave: in_*, ex_*, wb_*, stall)
//   OPFETCH_WB_BYPASS_EN: a same-cycle writeback to a source feeds the operand and clears its hazard
module opfetch_stage
  import proc_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  opfetch_if.slave  bus
);
  logic [OP_W-1:0]    op;
  logic [ADDR_W-1:0]  rd, rs1, rs2;
  logic [DATA_W-1:0]  rf_a, rf_b;
  logic               byp1, byp2, hazard, accept;
  logic [REG_CNT-1:0] pend_q, pend_d;
  logic               ex_valid_q, ex_valid_d;
  logic [OP_W-1:0]    ex_op_q, ex_op_d;
  logic [ADDR_W-1:0]  ex_rd_q, ex_rd_d;
  logic [DATA_W-1:0]  ex_a_q, ex_a_d, ex_b_q, ex_b_d;
  logic               unused_rsvd;
  assign op          = bus.in_instr[OP_LSB +: OP_W];
  assign rd          = bus.in_instr[RD_LSB +: ADDR_W];
  assign rs1         = bus.in_instr[RS1_LSB +: ADDR_W];
  assign rs2         = bus.in_instr[RS2_LSB +: ADDR_W];
  assign unused_rsvd = ^bus.in_instr[RS2_LSB-1:0];
  regfile_8x8 u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (rs1),
    .ra2   (rs2),
    .rd1   (rf_a),
    .rd2   (rf_b),
    .we    (bus.wb_en),
    .wa    (bus.wb_addr),
    .wd    (bus.wb_data)
  );
`ifdef OPFETCH_WB_BYPASS_EN
  assign byp1 = bus.wb_en && bus.wb_addr == rs1;
  assign byp2 = bus.wb_en && bus.wb_addr == rs2;
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif
  always_comb begin
    hazard       = (pend_q[rs1] && !byp1) || (pend_q[rs2] && !byp2);
    bus.in_ready = (!ex_valid_q || bus.ex_ready) && !hazard;
    bus.stall    = bus.in_valid && hazard;
    accept       = bus.in_valid && bus.in_ready;
    ex_valid_d   = accept ? 1'b1 : (bus.ex_ready ? 1'b0 : ex_valid_q);
    ex_op_d      = accept ? op   : ex_op_q;
    ex_rd_d      = accept ? rd   : ex_rd_q;
    ex_a_d       = accept ? rf_a : ex_a_q;
    ex_b_d       = accept ? rf_b : ex_b_q;
    pend_d       = pend_q;
    // clear before set so an accept to the register being written back keeps it pending
    if (bus.wb_en) pend_d[bus.wb_addr] = 1'b0;
    if (accept && op != OP_NOP) pend_d[rd] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q     <= '0;
      ex_valid_q <= 1'b0;
      ex_op_q    <= '0;
      ex_rd_q    <= '0;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
    end else begin
      pend_q     <= pend_d;
      ex_valid_q <= ex_valid_d;
      ex_op_q    <= ex_op_d;
      ex_rd_q    <= ex_rd_d;
      ex_a_q     <= ex_a_d;
      ex_b_q     <= ex_b_d;
    end
  end
  assign bus.ex_valid = ex_valid_q;
  assign bus.ex_op    = ex_op_q;
  assign bus.ex_rd    = ex_rd_q;
  assign bus.ex_a     = ex_a_q;
  assign bus.ex_b     = ex_b_q;
endmodule

// File: tb/tb_opfetch_stage.sv
// tb_opfetch_stage: directed and random stimulus checked against an array-based reference model
module tb_opfetch_stage;
`ifdef OPFETCH_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_fail = 0;
  always #5 clk = ~clk;
  opfetch_if bus ();
  opfetch_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [7:0] m_reg [8];
  bit         m_pend [8];
  bit         m_v;
  logic [3:0] m_op;
  logic [2:0] m_rd;
  logic [7:0] m_a, m_b;
  function automatic logic [15:0] ins(input int op, rd, rs1, rs2);
    return {op[3:0], rd[2:0], rs1[2:0], rs2[2:0], 3'b000};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step(input string tag, input bit rn, input bit iv, input logic [15:0] iw,
                      input bit er, input bit we, input logic [2:0] wa, input logic [7:0] wd);
    logic [3:0] op;
    logic [2:0] rd, s1, s2;
    bit b1, b2, hz, rdy, acc;
    @(negedge clk);
    rst_n = rn; bus.in_valid = iv; bus.in_instr = iw; bus.ex_ready = er;
    bus.wb_en = we; bus.wb_addr = wa; bus.wb_data = wd;
    #1;
    op = iw[15:12]; rd = iw[11:9]; s1 = iw[8:6]; s2 = iw[5:3];
    b1  = BYP && we && wa == s1;
    b2  = BYP && we && wa == s2;
    hz  = (m_pend[s1] && !b1) || (m_pend[s2] && !b2);
    rdy = (!m_v || er) && !hz;
    acc = iv && rdy;
    chk({tag, ".ex"}, {8'h0, bus.ex_valid, bus.ex_op, bus.ex_rd, bus.ex_a, bus.ex_b},
        {8'h0, m_v, m_op, m_rd, m_a, m_b});
    chk({tag, ".in_ready"}, {31'h0, bus.in_ready}, {31'h0, rdy});
    chk({tag, ".stall"}, {31'h0, bus.stall}, {31'h0, iv && hz});
    @(posedge clk);
    if (!rn) begin
      foreach (m_reg[i]) begin m_reg[i] = 8'h00; m_pend[i] = 1'b0; end
      m_v = 1'b0; m_op = '0; m_rd = '0; m_a = '0; m_b = '0;
    end else begin
      if (acc) begin
        m_v = 1'b1; m_op = op; m_rd = rd;
        m_a = b1 ? wd : m_reg[s1];
        m_b = b2 ? wd : m_reg[s2];
      end else if (er) m_v = 1'b0;
      if (we) begin m_reg[wa] = wd; m_pend[wa] = 1'b0; end
      if (acc && op != 4'h0) m_pend[rd] = 1'b1;
    end
  endtask
  initial begin
    foreach (m_reg[i]) begin m_reg[i] = 8'h00; m_pend[i] = 1'b0; end
    m_v = 1'b0; m_op = '0; m_rd = '0; m_a = '0; m_b = '0;
    rst_n = 1'b0; bus.in_valid = 1'b1; bus.in_instr = ins(1, 1, 0, 0); bus.ex_ready = 1'b1;
    bus.wb_en = 1'b1; bus.wb_addr = 3'd1; bus.wb_data = 8'h55;
    @(posedge clk);
    step("rst",      0, 1, ins(1, 1, 0, 0), 1, 1, 3'd1, 8'h55);
    step("rst_rel",  1, 1, ins(0, 0, 1, 1), 1, 0, 3'd0, 8'h00);
    step("rst_chk",  1, 0, 16'h0, 1, 0, 3'd0, 8'h00);
    step("wb_r1",    1, 0, 16'h0, 1, 1, 3'd1, 8'hF0);
    step("wb_r2",    1, 0, 16'h0, 1, 1, 3'd2, 8'h3C);
    step("idle",     1, 0, 16'h0, 1, 0, 3'd0, 8'h00);
    step("issue3",   1, 1, ins(1, 3, 1, 2), 1, 0, 3'd0, 8'h00);
    step("ex3",      1, 0, 16'h0, 1, 0, 3'd0, 8'h00);
    step("raw_w4",   1, 1, ins(1, 4, 1, 2), 1, 0, 3'd0, 8'h00);
    step("raw_st1",  1, 1, ins(2, 5, 4, 1), 1, 0, 3'd0, 8'h00);
    step("raw_st2",  1, 1, ins(2, 5, 4, 1), 1, 0, 3'd0, 8'h00);
    step("raw_wb",   1, 1, ins(2, 5, 4, 1), 1, 1, 3'd4, 8'hAA);
    step("raw_post", 1, !BYP, ins(2, 5, 4, 1), 1, 0, 3'd0, 8'h00);
    step("raw_ex",   1, 0, 16'h0, 1, 0, 3'd0, 8'h00);
    step("bp_acc",   1, 1, ins(3, 6, 1, 2), 0, 1, 3'd3, 8'h11);
    step("bp_h1",    1, 1, ins(4, 7, 2, 1), 0, 0, 3'd0, 8'h00);
    step("bp_h2",    1, 1, ins(4, 7, 2, 1), 0, 0, 3'd0, 8'h00);
    step("bp_h3",    1, 1, ins(4, 7, 2, 1), 0, 0, 3'd0, 8'h00);
    step("bp_go",    1, 1, ins(4, 7, 2, 1), 1, 0, 3'd0, 8'h00);
    step("bp_ex",    1, 0, 16'h0, 1, 0, 3'd0, 8'h00);
    step("col_clr5", 1, 0, 16'h0, 1, 1, 3'd5, 8'h22);
    step("col",      1, 1, ins(5, 5, 1, 2), 1, 1, 3'd5, 8'h33);
    step("col_st1",  1, 1, ins(6, 0, 5, 1), 1, 0, 3'd0, 8'h00);
    step("col_st2",  1, 1, ins(6, 0, 5, 1), 1, 0, 3'd0, 8'h00);
    step("col_wb5",  1, 1, ins(6, 0, 5, 1), 1, 1, 3'd5, 8'h44);
    step("col_post", 1, !BYP, ins(6, 0, 5, 1), 1, 0, 3'd0, 8'h00);
    step("nop_clr",  1, 0, 16'h0, 1, 1, 3'd6, 8'h66);
    step("nop_clr2", 1, 0, 16'h0, 1, 1, 3'd7, 8'h77);
    step("nop",      1, 1, ins(0, 6, 1, 2), 1, 0, 3'd0, 8'h00);
    step("nop_rd6",  1, 1, ins(1, 1, 6, 6), 1, 0, 3'd0, 8'h00);
    step("nop_ex",   1, 0, 16'h0, 1, 1, 3'd1, 8'h01);
    for (int i = 0; i < 400; i++)
      step("rand", ($urandom_range(0, 63) != 0), ($urandom_range(0, 3) != 0), 16'($urandom),
           ($urandom_range(0, 3) != 0), 1'($urandom), 3'($urandom), 8'($urandom));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
